arm_mem_dumper: RTL and testbench

//  Readback engine for arm_memory port 2: after arm_core halts, streams COUNT words from BASE

---
 rtl/arm_mem_dumper_pkg.sv | 25 ++
 rtl/arm_mem_dumper_if.sv | 29 ++
 rtl/arm_stream_reg.sv | 29 ++
 rtl/arm_mem_dumper.sv | 129 ++++++++++++
 tb/tb_arm_mem_dumper.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_dumper_pkg.sv
// Shared types and constants for the arm_memory port-2 readback engine.
package arm_mem_dumper_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_ISSUE = 2'd1,
    DUMP_WAIT  = 2'd2,
    DUMP_HOLD  = 2'd3
  } dump_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dump_beat_t;

  // Clear the byte-offset bits so every access is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/arm_mem_dumper_if.sv
// Control, memory-port and output-stream signals of the dumper.
interface arm_mem_dumper_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic                                  start;
  logic [arm_mem_dumper_pkg::ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]                      word_count;
  logic                                  busy;
  logic                                  done;
  logic [arm_mem_dumper_pkg::ADDR_W-1:0] mem_addr;
  logic                                  mem_write_en;
  logic [arm_mem_dumper_pkg::DATA_W-1:0] mem_data_out;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [arm_mem_dumper_pkg::ADDR_W-1:0] out_addr;
  logic [arm_mem_dumper_pkg::DATA_W-1:0] out_data;

  modport master (
    input  start, base_addr, word_count, mem_data_out, out_ready,
    output busy, done, mem_addr, mem_write_en, out_valid, out_addr, out_data
  );

  modport slave (
    output start, base_addr, word_count, mem_data_out, out_ready,
    input  busy, done, mem_addr, mem_write_en, out_valid, out_addr, out_data
  );

endinterface

// File: rtl/arm_stream_reg.sv
// Valid/ready holding register: keeps one beat stable until the consumer takes it.
module arm_stream_reg
  import arm_mem_dumper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  dump_beat_t load_beat,
  input  logic       ready,
  output logic       valid,
  output dump_beat_t beat,
  output logic       fire_c
);

  assign fire_c = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= load_beat;
    end else if (fire_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arm_mem_dumper.sv
// Streams word_count words from base_addr upward out of arm_memory port 2.
module arm_mem_dumper
  import arm_mem_dumper_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  arm_mem_dumper_if.master  bus
);

  localparam int unsigned WAIT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  dump_state_e        state, state_next;
  logic [ADDR_W-1:0]  cur_addr, cur_addr_next;
  logic [ADDR_W-1:0]  mem_addr, mem_addr_next;
  logic [CNT_W-1:0]   remaining, remaining_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
  logic               busy, busy_next;
  logic               done, done_next;
  logic               load_c;
  logic               fire_c;
  dump_beat_t         load_beat;
  dump_beat_t         beat;
  logic               out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DUMP_IDLE;
      cur_addr  <= '0;
      mem_addr  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      mem_addr  <= mem_addr_next;
      remaining <= remaining_next;
      wait_cnt  <= wait_cnt_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // mem_addr is loaded on entry to ISSUE so the read address is stable for the whole access.
  always_comb begin
    state_next     = state;
    cur_addr_next  = cur_addr;
    mem_addr_next  = mem_addr;
    remaining_next = remaining;
    wait_cnt_next  = wait_cnt;
    done_next      = 1'b0;
    load_c         = 1'b0;

    case (state)
      DUMP_IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            cur_addr_next  = word_align(bus.base_addr);
            mem_addr_next  = word_align(bus.base_addr);
            remaining_next = bus.word_count;
            state_next     = DUMP_ISSUE;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      DUMP_ISSUE: begin
        if (MEM_RD_LAT == 0) begin
          load_c     = 1'b1;
          state_next = DUMP_HOLD;
        end else begin
          wait_cnt_next = WAIT_W'(MEM_RD_LAT - 1);
          state_next    = DUMP_WAIT;
        end
      end
      DUMP_WAIT: begin
        if (wait_cnt == '0) begin
          load_c     = 1'b1;
          state_next = DUMP_HOLD;
        end else begin
          wait_cnt_next = wait_cnt - WAIT_W'(1);
        end
      end
      DUMP_HOLD: begin
        if (fire_c) begin
          if (remaining == CNT_W'(1)) begin
            done_next  = 1'b1;
            state_next = DUMP_IDLE;
          end else begin
            remaining_next = remaining - CNT_W'(1);
            cur_addr_next  = cur_addr + ADDR_W'(WORD_BYTES);
            mem_addr_next  = cur_addr + ADDR_W'(WORD_BYTES);
            state_next     = DUMP_ISSUE;
          end
        end
      end
      default: state_next = DUMP_IDLE;
    endcase

    busy_next = (state_next != DUMP_IDLE);
  end

  assign load_beat.addr = cur_addr;
  assign load_beat.data = bus.mem_data_out;

  arm_stream_reg u_stream_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_beat (load_beat),
    .ready     (bus.out_ready),
    .valid     (out_valid),
    .beat      (beat),
    .fire_c    (fire_c)
  );

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_write_en = 1'b0;
  assign bus.out_valid    = out_valid;
  assign bus.out_addr     = beat.addr;
  assign bus.out_data     = beat.data;

endmodule

// File: tb/tb_arm_mem_dumper.sv
// Directed bench: three dumper builds (read latency 0/1/2) share one stimulus and memory image.
module tb_arm_mem_dumper;
  import arm_mem_dumper_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [15:0] count;
  logic        ready;
  logic [31:0] mem [16];
  logic [31:0] m2_stage;

  always #5 clk = ~clk;

  arm_mem_dumper_if #(.CNT_W(CNT_W)) b0 ();
  arm_mem_dumper_if #(.CNT_W(CNT_W)) b1 ();
  arm_mem_dumper_if #(.CNT_W(CNT_W)) b2 ();

  assign b0.start = start;  assign b0.base_addr = base;  assign b0.word_count = count;  assign b0.out_ready = ready;
  assign b1.start = start;  assign b1.base_addr = base;  assign b1.word_count = count;  assign b1.out_ready = ready;
  assign b2.start = start;  assign b2.base_addr = base;  assign b2.word_count = count;  assign b2.out_ready = ready;

  // Memory models with 0, 1 and 2 cycles of read latency.
  assign b0.mem_data_out = mem[b0.mem_addr[5:2]];
  always @(posedge clk) b1.mem_data_out <= mem[b1.mem_addr[5:2]];
  always @(posedge clk) begin
    m2_stage         <= mem[b2.mem_addr[5:2]];
    b2.mem_data_out  <= m2_stage;
  end

  arm_mem_dumper #(.MEM_RD_LAT(0), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));
  arm_mem_dumper #(.MEM_RD_LAT(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  arm_mem_dumper #(.MEM_RD_LAT(2), .CNT_W(CNT_W)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));

  int checks = 0;
  int passes = 0;
  int cyc;
  int first_v [3];
  int n_hs [3];
  int done_cyc, done_cnt, overlap, unstable, stall_cnt;
  logic busy_seen, valid_seen, we_high;
  logic hold_pend;
  logic [31:0] hold_addr, hold_data;
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  always @(negedge clk)
    if (b0.mem_write_en !== 1'b0 || b1.mem_write_en !== 1'b0 || b2.mem_write_en !== 1'b0)
      we_high = 1'b1;

  task automatic clear_rec();
    cyc = 0; done_cyc = -1; done_cnt = 0; overlap = 0; unstable = 0; stall_cnt = 0;
    busy_seen = 1'b0; valid_seen = 1'b0; hold_pend = 1'b0;
    for (int i = 0; i < 3; i++) begin first_v[i] = -1; n_hs[i] = 0; end
    q_addr.delete(); q_data.delete();
  endtask

  // Observe the current cycle (inputs already applied), then advance one clock.
  task automatic step();
    if (hold_pend && (b1.out_valid !== 1'b1 || b1.out_addr !== hold_addr || b1.out_data !== hold_data))
      unstable++;
    hold_pend = b1.out_valid && !ready;
    hold_addr = b1.out_addr;
    hold_data = b1.out_data;
    if (b1.out_valid && !ready) stall_cnt++;
    if (b1.out_valid && ready) begin q_addr.push_back(b1.out_addr); q_data.push_back(b1.out_data); end
    if (b0.out_valid && ready) n_hs[0]++;
    if (b1.out_valid && ready) n_hs[1]++;
    if (b2.out_valid && ready) n_hs[2]++;
    if (b0.out_valid && first_v[0] < 0) first_v[0] = cyc;
    if (b1.out_valid && first_v[1] < 0) first_v[1] = cyc;
    if (b2.out_valid && first_v[2] < 0) first_v[2] = cyc;
    if (b1.done) begin done_cnt++; done_cyc = cyc; end
    if (b1.done && b1.out_valid) overlap++;
    if (b1.busy) busy_seen = 1'b1;
    if (b1.out_valid) valid_seen = 1'b1;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base = '0; count = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({b1.busy, b1.done, b1.out_valid} !== 3'b000) $display("FAIL reset_flags got %b want 000", {b1.busy, b1.done, b1.out_valid}); else passes++;
    checks++; if (b1.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 00000000", b1.mem_addr); else passes++;
    checks++; if ({b1.out_addr, b1.out_data} !== 64'h0) $display("FAIL reset_out got %h want 0", {b1.out_addr, b1.out_data}); else passes++;
    checks++; if (b1.mem_write_en !== 1'b0) $display("FAIL reset_we got %b want 0", b1.mem_write_en); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_rec();
    base = 32'h0; count = 16'd3; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    repeat (15) step();
    checks++; if (q_addr.size() != 3) $display("FAIL basic_beats got %0d want 3", q_addr.size()); else passes++;
    if (q_addr.size() == 3) begin
      checks++; if ({q_addr[0], q_data[0]} !== {32'h0, 32'h11111111}) $display("FAIL basic_beat0 got %h/%h want 0/11111111", q_addr[0], q_data[0]); else passes++;
      checks++; if ({q_addr[1], q_data[1]} !== {32'h4, 32'h22222222}) $display("FAIL basic_beat1 got %h/%h want 4/22222222", q_addr[1], q_data[1]); else passes++;
      checks++; if ({q_addr[2], q_data[2]} !== {32'h8, 32'h33333333}) $display("FAIL basic_beat2 got %h/%h want 8/33333333", q_addr[2], q_data[2]); else passes++;
    end
    checks++; if (first_v[1] != 3) $display("FAIL basic_first_valid got %0d want 3", first_v[1]); else passes++;
    checks++; if (done_cyc != 10 || done_cnt != 1) $display("FAIL basic_done got cyc %0d cnt %0d want 10/1", done_cyc, done_cnt); else passes++;
    checks++; if (overlap != 0) $display("FAIL basic_done_overlap got %0d want 0", overlap); else passes++;
    checks++; if (b1.busy !== 1'b0) $display("FAIL basic_idle_busy got %b want 0", b1.busy); else passes++;
  endtask

  task automatic test_backpressure();
    clear_rec();
    base = 32'h0; count = 16'd3; start = 1'b1;
    for (int c = 0; c < 22; c++) begin
      ready = !(cyc >= 6 && cyc < 11);
      step();
      start = 1'b0;
    end
    ready = 1'b1;
    checks++; if (q_addr.size() != 3) $display("FAIL bp_beats got %0d want 3", q_addr.size()); else passes++;
    if (q_addr.size() == 3) begin
      checks++; if ({q_addr[1], q_data[1]} !== {32'h4, 32'h22222222}) $display("FAIL bp_beat1 got %h/%h want 4/22222222", q_addr[1], q_data[1]); else passes++;
      checks++; if ({q_addr[2], q_data[2]} !== {32'h8, 32'h33333333}) $display("FAIL bp_beat2 got %h/%h want 8/33333333", q_addr[2], q_data[2]); else passes++;
    end
    checks++; if (stall_cnt != 5) $display("FAIL bp_stall_cycles got %0d want 5", stall_cnt); else passes++;
    checks++; if (unstable != 0) $display("FAIL bp_stable got %0d changes want 0", unstable); else passes++;
    checks++; if (done_cyc != 15) $display("FAIL bp_done got %0d want 15", done_cyc); else passes++;
  endtask

  task automatic test_zero_count();
    clear_rec();
    base = 32'h40; count = 16'd0; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    repeat (5) step();
    checks++; if (done_cyc != 1 || done_cnt != 1) $display("FAIL zero_done got cyc %0d cnt %0d want 1/1", done_cyc, done_cnt); else passes++;
    checks++; if (busy_seen || valid_seen) $display("FAIL zero_quiet got busy %b valid %b want 0/0", busy_seen, valid_seen); else passes++;
    checks++; if (b1.mem_addr !== 32'h8) $display("FAIL zero_mem_addr got %h want 00000008", b1.mem_addr); else passes++;
  endtask

  task automatic test_addr_align_wrap();
    clear_rec();
    base = 32'h0000000A; count = 16'd2; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    repeat (10) step();
    checks++; if (q_addr.size() != 2) $display("FAIL align_beats got %0d want 2", q_addr.size()); else passes++;
    if (q_addr.size() == 2) begin
      checks++; if ({q_addr[0], q_data[0]} !== {32'h8, 32'h33333333}) $display("FAIL align_beat0 got %h/%h want 8/33333333", q_addr[0], q_data[0]); else passes++;
      checks++; if ({q_addr[1], q_data[1]} !== {32'hC, 32'h44444444}) $display("FAIL align_beat1 got %h/%h want c/44444444", q_addr[1], q_data[1]); else passes++;
    end
    clear_rec();
    base = 32'hFFFFFFFC; count = 16'd2; start = 1'b1;
    step(); start = 1'b0;
    repeat (10) step();
    checks++; if (q_addr.size() != 2) $display("FAIL wrap_beats got %0d want 2", q_addr.size()); else passes++;
    if (q_addr.size() == 2) begin
      checks++; if ({q_addr[0], q_data[0]} !== {32'hFFFFFFFC, 32'hA000000F}) $display("FAIL wrap_beat0 got %h/%h want fffffffc/a000000f", q_addr[0], q_data[0]); else passes++;
      checks++; if ({q_addr[1], q_data[1]} !== {32'h0, 32'h11111111}) $display("FAIL wrap_beat1 got %h/%h want 0/11111111", q_addr[1], q_data[1]); else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL wrap_done got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_reset_abort();
    clear_rec();
    base = 32'h0; count = 16'd3; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    repeat (5) step();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_addr !== 32'h4) $display("FAIL abort_in_hold got v %b a %h want 1/4", b1.out_valid, b1.out_addr); else passes++;
    ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b1;
    checks++; if ({b1.out_valid, b1.busy, b1.done} !== 3'b000) $display("FAIL abort_idle got %b want 000", {b1.out_valid, b1.busy, b1.done}); else passes++;
    clear_rec();
    repeat (4) step();
    checks++; if (done_cnt != 0 || valid_seen) $display("FAIL abort_quiet got done %0d valid %b want 0/0", done_cnt, valid_seen); else passes++;
    clear_rec();
    base = 32'h8; count = 16'd2; start = 1'b1;
    step();
    base = 32'h0; count = 16'd1;
    step();
    step();
    start = 1'b0;
    repeat (12) step();
    checks++; if (q_addr.size() != 2) $display("FAIL restart_beats got %0d want 2", q_addr.size()); else passes++;
    if (q_addr.size() == 2) begin
      checks++; if ({q_addr[0], q_data[0]} !== {32'h8, 32'h33333333}) $display("FAIL restart_beat0 got %h/%h want 8/33333333", q_addr[0], q_data[0]); else passes++;
      checks++; if ({q_addr[1], q_data[1]} !== {32'hC, 32'h44444444}) $display("FAIL restart_beat1 got %h/%h want c/44444444", q_addr[1], q_data[1]); else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL restart_done got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_latency_builds();
    clear_rec();
    base = 32'h0; count = 16'd3; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    repeat (20) step();
    checks++; if (first_v[0] != 2) $display("FAIL lat0_first_valid got %0d want 2", first_v[0]); else passes++;
    checks++; if (first_v[1] != 3) $display("FAIL lat1_first_valid got %0d want 3", first_v[1]); else passes++;
    checks++; if (first_v[2] != 4) $display("FAIL lat2_first_valid got %0d want 4", first_v[2]); else passes++;
    checks++; if (n_hs[0] != 3 || n_hs[2] != 3) $display("FAIL lat_beat_counts got %0d/%0d want 3/3", n_hs[0], n_hs[2]); else passes++;
    checks++; if (we_high !== 1'b0) $display("FAIL write_en_low got %b want 0", we_high); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA0000000 | 32'(i);
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    we_high = 1'b0;
    clear_rec();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_addr_align_wrap();
    test_reset_abort();
    test_latency_builds();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
